// File: rtl/enc_pkg.sv
// Shared step encoding and the quadrature transition table for the encoder array.
package enc_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  // Forward (A leads) successor of a {A,B} Gray state: 00->10->11->01->00.
  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    logic [1:0] r;
    case (ab)
      2'b00:   r = 2'b10;
      2'b10:   r = 2'b11;
      2'b11:   r = 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_e s;
    if (cur == prev)                s = STEP_NONE;
    else if (cur == fwd_next(prev)) s = STEP_FWD;
    else if (prev == fwd_next(cur)) s = STEP_REV;
    else                            s = STEP_ERR;
    return s;
  endfunction

endpackage

// File: rtl/quad_encoder_array_if.sv
// Encoder inputs and measurement outputs of the encoder array, bundled as one port.
interface quad_encoder_array_if #(
  parameter int NCH   = 4,
  parameter int POS_W = 32,
  parameter int VEL_W = 16
);
  logic [NCH-1:0]       enc_a;
  logic [NCH-1:0]       enc_b;
  logic [NCH-1:0]       clr_pos;
  logic                 err_clr;
  logic [NCH*POS_W-1:0] pos_o;
  logic [NCH*VEL_W-1:0] vel_o;
  logic                 vel_valid;
  logic [NCH-1:0]       dir_o;
  logic [NCH-1:0]       err_o;

  modport slave (
    input  enc_a, enc_b, clr_pos, err_clr,
    output pos_o, vel_o, vel_valid, dir_o, err_o
  );

  modport master (
    output enc_a, enc_b, clr_pos, err_clr,
    input  pos_o, vel_o, vel_valid, dir_o, err_o
  );
endinterface

// File: rtl/quad_encoder_array_ch.sv
// One encoder channel: synchroniser, glitch filter, 4x decode, position,
// windowed velocity accumulator, direction and sticky error.
module quad_decoder_ch
  import enc_pkg::*;
#(
  parameter int POS_W    = 32,
  parameter int VEL_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr_pos,
  input  logic             err_clr,
  input  logic             window_tick,
  output logic [POS_W-1:0] pos,
  output logic [VEL_W-1:0] vel,
  output logic             dir,
  output logic             err
);

  localparam int AW   = VEL_W + 1;
  localparam int CW   = $clog2(FILT_LEN + 1);
  localparam int PW   = $clog2(FILT_LEN + 3);
  localparam logic [CW-1:0] FMAX = CW'(FILT_LEN - 1);
  // Sync + filter latency: the filter output is trustworthy after this many edges.
  localparam logic [PW-1:0] PMAX = PW'(FILT_LEN + 2);

  logic [1:0]          s1, s2, filt, prev;
  logic [1:0][CW-1:0]  fcnt;
  logic [PW-1:0]       pcnt;
  logic                primed;
  step_e               step;
  logic [AW:0]         d, sum;
  logic [AW-1:0]       acc, acc_nx;
  logic [VEL_W-1:0]    vel_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      filt <= '0;
      fcnt <= '0;
    end else begin
      s1 <= {a, b};
      s2 <= s1;
      for (int k = 0; k < 2; k++) begin
        if (s2[k] != filt[k]) begin
          if (fcnt[k] == FMAX) begin
            filt[k] <= s2[k];
            fcnt[k] <= '0;
          end else begin
            fcnt[k] <= fcnt[k] + CW'(1);
          end
        end else begin
          fcnt[k] <= '0;
        end
      end
    end
  end

  // Until the pipeline has filled, prev only tracks filt so an idle non-00 level is not an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= '0;
      pcnt   <= '0;
      primed <= 1'b0;
    end else begin
      prev <= filt;
      if (!primed) begin
        if (pcnt == PMAX) primed <= 1'b1;
        else              pcnt   <= pcnt + PW'(1);
      end
    end
  end

  assign step = primed ? decode_step(prev, filt) : STEP_NONE;

  always_comb begin
    d = '0;
    if (step == STEP_FWD)      d = {{AW{1'b0}}, 1'b1};
    else if (step == STEP_REV) d = '1;
    sum    = {acc[AW-1], acc} + d;
    acc_nx = sum[AW-1:0];
    if (sum[AW] != sum[AW-1])
      acc_nx = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    vel_nx = sum[VEL_W-1:0];
    if (!(&sum[AW:VEL_W-1]) && (|sum[AW:VEL_W-1]))
      vel_nx = sum[AW] ? {1'b1, {(VEL_W-1){1'b0}}} : {1'b0, {(VEL_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
      vel <= '0;
      acc <= '0;
      dir <= 1'b0;
      err <= 1'b0;
    end else begin
      if (clr_pos)               pos <= '0;
      else if (step == STEP_FWD) pos <= pos + POS_W'(1);
      else if (step == STEP_REV) pos <= pos - POS_W'(1);

      if (step == STEP_FWD)      dir <= 1'b1;
      else if (step == STEP_REV) dir <= 1'b0;

      if (step == STEP_ERR) err <= 1'b1;
      else if (err_clr)     err <= 1'b0;

      if (window_tick) begin
        vel <= vel_nx;
        acc <= '0;
      end else begin
        acc <= acc_nx;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_array.sv
// Multi-channel quadrature encoder interface: NCH decoder channels sharing one
// velocity window timer.
module quad_encoder_array #(
  parameter int NCH           = 4,
  parameter int POS_W         = 32,
  parameter int VEL_W         = 16,
  parameter int FILT_LEN      = 4,
  parameter int SAMPLE_CYCLES = 50000
) (
  input logic               clk,
  input logic               rst_n,
  quad_encoder_array_if.slave bus
);

  localparam int TW = $clog2(SAMPLE_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(SAMPLE_CYCLES - 1);

  logic [TW-1:0]             tcnt;
  logic                      tick;
  logic                      vld_r;
  logic [NCH-1:0][POS_W-1:0] pos_w;
  logic [NCH-1:0][VEL_W-1:0] vel_w;
  logic [NCH-1:0]            dir_w;
  logic [NCH-1:0]            err_w;

  assign tick = (tcnt == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      vld_r <= 1'b0;
    end else begin
      tcnt  <= tick ? '0 : tcnt + TW'(1);
      vld_r <= tick;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    quad_decoder_ch #(
      .POS_W    (POS_W),
      .VEL_W    (VEL_W),
      .FILT_LEN (FILT_LEN)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (bus.enc_a[i]),
      .b           (bus.enc_b[i]),
      .clr_pos     (bus.clr_pos[i]),
      .err_clr     (bus.err_clr),
      .window_tick (tick),
      .pos         (pos_w[i]),
      .vel         (vel_w[i]),
      .dir         (dir_w[i]),
      .err         (err_w[i])
    );
  end

  assign bus.pos_o     = pos_w;
  assign bus.vel_o     = vel_w;
  assign bus.vel_valid = vld_r;
  assign bus.dir_o     = dir_w;
  assign bus.err_o     = err_w;

endmodule

// File: tb/tb_quad_encoder_array.sv
// Directed bench for quad_encoder_array: a 16-bit velocity instance and a 4-bit
// velocity instance fed from the same encoder inputs.
module tb_quad_encoder_array;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;
  logic [1:0] ab0;

  always #5 clk = ~clk;

  quad_encoder_array_if #(.NCH(2), .POS_W(32), .VEL_W(16)) bus ();
  quad_encoder_array_if #(.NCH(2), .POS_W(32), .VEL_W(4))  bus4 ();

  assign bus4.enc_a   = bus.enc_a;
  assign bus4.enc_b   = bus.enc_b;
  assign bus4.clr_pos = bus.clr_pos;
  assign bus4.err_clr = bus.err_clr;

  quad_encoder_array #(.NCH(2), .POS_W(32), .VEL_W(16), .FILT_LEN(2), .SAMPLE_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  quad_encoder_array #(.NCH(2), .POS_W(32), .VEL_W(4), .FILT_LEN(2), .SAMPLE_CYCLES(100)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  function automatic logic [1:0] fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic [1:0] ab);
    bus.enc_a[0] = ab[1];
    bus.enc_b[0] = ab[0];
  endtask

  task automatic wait_valid(input int max, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.vel_valid !== 1'b1 && n < max);
    check(tag, {63'd0, bus.vel_valid}, 64'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.enc_a   = 2'b11;
    bus.enc_b   = 2'b11;
    bus.clr_pos = 2'b00;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pos", bus.pos_o, 64'd0);
    check("rst_vel", {32'd0, bus.vel_o}, 64'd0);
    check("rst_vvalid", {63'd0, bus.vel_valid}, 64'd0);
    check("rst_dir", {62'd0, bus.dir_o}, 64'd0);
    check("rst_err", {62'd0, bus.err_o}, 64'd0);

    // Idle at 11 through reset must not count or flag.
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle11_pos", bus.pos_o, 64'd0);
    check("idle11_err", {62'd0, bus.err_o}, 64'd0);
    check("idle11_dir", {62'd0, bus.dir_o}, 64'd0);

    ab0 = 2'b11;
    for (int i = 0; i < 8; i++) begin
      ab0 = fwd(ab0);
      set0(ab0);
      repeat (10) @(negedge clk);
    end
    check("fwd8_pos0", {32'd0, bus.pos_o[31:0]}, 64'd8);
    check("fwd8_dir0", {63'd0, bus.dir_o[0]}, 64'd1);
    check("fwd8_pos1", {32'd0, bus.pos_o[63:32]}, 64'd0);

    bus.clr_pos = 2'b01;
    @(negedge clk);
    bus.clr_pos = 2'b00;
    check("clr_pos0", {32'd0, bus.pos_o[31:0]}, 64'd0);

    // First reverse step: unchanged after 4 edges, -1 after the 5th.
    ab0 = rev(ab0);
    set0(ab0);
    repeat (4) @(negedge clk);
    check("lat_hold", {32'd0, bus.pos_o[31:0]}, 64'd0);
    @(negedge clk);
    check("lat_step", {32'd0, bus.pos_o[31:0]}, 64'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ab0 = rev(ab0);
      set0(ab0);
      repeat (10) @(negedge clk);
    end
    check("rev3_pos0", {32'd0, bus.pos_o[31:0]}, 64'hFFFF_FFFD);
    check("rev3_dir0", {63'd0, bus.dir_o[0]}, 64'd0);

    bus.enc_a[0] = ~ab0[1];
    @(negedge clk);
    bus.enc_a[0] = ab0[1];
    repeat (10) @(negedge clk);
    check("glitch_pos0", {32'd0, bus.pos_o[31:0]}, 64'hFFFF_FFFD);
    check("glitch_err", {62'd0, bus.err_o}, 64'd0);

    ab0 = fwd(ab0);  // 01 -> 00
    set0(ab0);
    repeat (10) @(negedge clk);
    check("to00_pos0", {32'd0, bus.pos_o[31:0]}, 64'hFFFF_FFFE);

    ab0 = 2'b11;
    set0(ab0);
    repeat (10) @(negedge clk);
    check("jump_err", {62'd0, bus.err_o}, 64'd1);
    check("jump_pos0", {32'd0, bus.pos_o[31:0]}, 64'hFFFF_FFFE);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("errclr", {62'd0, bus.err_o}, 64'd0);

    // Illegal jump landing on the same edge as err_clr keeps the flag.
    ab0 = 2'b00;
    set0(ab0);
    repeat (4) @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("err_vs_clr", {62'd0, bus.err_o}, 64'd1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("errclr2", {62'd0, bus.err_o}, 64'd0);

    wait_valid(250, "sync_win");
    for (int i = 0; i < 40; i++) begin
      ab0 = fwd(ab0);
      set0(ab0);
      repeat (2) @(negedge clk);
    end
    wait_valid(150, "win40_valid");
    check("win40_vel0", {48'd0, bus.vel_o[15:0]}, 64'd40);
    check("win40_vel1", {48'd0, bus.vel_o[31:16]}, 64'd0);
    check("win40_sat4", {60'd0, bus4.vel_o[3:0]}, 64'd7);
    check("win40_pos0", {32'd0, bus.pos_o[31:0]}, 64'd38);
    @(negedge clk);
    check("vvalid_pulse", {63'd0, bus.vel_valid}, 64'd0);
    wait_valid(150, "win0_valid");
    check("win0_vel0", {48'd0, bus.vel_o[15:0]}, 64'd0);
    check("win0_sat4", {60'd0, bus4.vel_o[3:0]}, 64'd0);

    // Clear on the landing edge of a step: step dropped from pos, kept in velocity.
    ab0 = fwd(ab0);
    set0(ab0);
    repeat (4) @(negedge clk);
    bus.clr_pos = 2'b01;
    @(negedge clk);
    bus.clr_pos = 2'b00;
    check("clrstep_pos0", {32'd0, bus.pos_o[31:0]}, 64'd0);
    check("clrstep_dir0", {63'd0, bus.dir_o[0]}, 64'd1);
    repeat (5) @(negedge clk);
    check("clrstep_hold", {32'd0, bus.pos_o[31:0]}, 64'd0);
    wait_valid(150, "win1_valid");
    check("win1_vel0", {48'd0, bus.vel_o[15:0]}, 64'd1);

    rst_n = 1'b0;
    #1;
    check("midrst_vel", {32'd0, bus.vel_o}, 64'd0);
    check("midrst_dir", {62'd0, bus.dir_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst_pos", bus.pos_o, 64'd0);
    check("postrst_err", {62'd0, bus.err_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
